// File: rtl/mul_arb_pkg.sv
// Shared types and width helpers for the multiplier arbiter.
package mul_arb_pkg;

  localparam int TAG_ID_W = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } mul_tag_t;

  function automatic int id_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/Multiplier.sv
// Fixed-latency pipelined multiplier; per-operand signedness, full 2*WIDTH product.
module Multiplier #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   op1,
  input  logic               op1_sign,
  input  logic [WIDTH-1:0]   op2,
  input  logic               op2_sign,
  output logic [2*WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] a_s, b_s, prod_s;
  logic [2*WIDTH-1:0] pipe_q [LATENCY];

  // The low 2*WIDTH bits of the extended product are exact for any sign mix.
  assign a_s    = {{WIDTH{op1_sign & op1[WIDTH-1]}}, op1};
  assign b_s    = {{WIDTH{op2_sign & op2[WIDTH-1]}}, op2};
  assign prod_s = a_s * b_s;

  // Result delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LATENCY; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= prod_s;
      for (int k = 1; k < LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign result = pipe_q[LATENCY-1];

endmodule

// File: rtl/mul_arb_resp_fifo.sv
// Per-requester response FIFO with occupancy count and asynchronous reset.
module mul_arb_resp_fifo
  import mul_arb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  localparam int CW    = cnt_w(DEPTH),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CW-1:0]     cnt_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pop_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_s = pop_i && (cnt_q != '0);

  // Occupancy next state; simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers and count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ptr_next(wr_q);
      end
      if (pop_s) rd_q <= ptr_next(rd_q);
      cnt_q <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_q];
  assign cnt_o   = cnt_q;

  mul_arb_resp_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push_i),
    .cnt_i   (cnt_q)
  );

endmodule

// File: rtl/mul_arb_resp_fifo_chk.sv
// Checker for one response FIFO: a push must never land on a full FIFO.
module mul_arb_resp_fifo_chk #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input logic          clk_i,
  input logic          rst_n_i,
  input logic          push_i,
  input logic [CW-1:0] cnt_i
);

  property p_no_push_full;
    @(posedge clk_i) disable iff (!rst_n_i) !(push_i && (cnt_i == CW'(DEPTH)));
  endproperty

  a_no_push_full: assert property (p_no_push_full);

endmodule

// File: rtl/mul_arbiter.sv
// Credit-gated round-robin sharing of one pipelined Multiplier among NUM_REQ requesters.
// Optional per-requester statistics ports when MUL_ARBITER_STATS_EN is defined.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 3,
  parameter int RESP_DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_op1,
  input  logic [NUM_REQ-1:0]         req_op1_sign,
  input  logic [NUM_REQ*WIDTH-1:0]   req_op2,
  input  logic [NUM_REQ-1:0]         req_op2_sign,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [NUM_REQ*2*WIDTH-1:0] rsp_result,
  output logic                       busy
`ifdef MUL_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]      stat_issue_cnt,
  output logic [NUM_REQ*32-1:0]      stat_stall_cnt
`endif
);

  localparam int IDW = id_w(NUM_REQ);
  localparam int CW  = cnt_w(RESP_DEPTH);
  localparam int DW  = 2 * WIDTH;

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    inflight_q [NUM_REQ];
  logic [CW-1:0]    inflight_d [NUM_REQ];
  logic [CW-1:0]    fifo_cnt_s [NUM_REQ];
  mul_tag_t         tag_q [MUL_LATENCY];
  mul_tag_t         tag_in_s, tail_s;
  logic [NUM_REQ-1:0] eligible_s, grant_s, push_s;
  logic             lo_found_s, hi_found_s, gnt_vld_s, busy_s;
  logic [IDW-1:0]   lo_idx_s, hi_idx_s, gnt_idx_s;
  logic [WIDTH-1:0] op1_s, op2_s;
  logic             op1_sign_s, op2_sign_s;
  logic [DW-1:0]    mul_result_s;

  // Credit uses registered counts only, so ready never depends on this cycle's pops.
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_s[i] = req_valid[i] &&
        (({1'b0, fifo_cnt_s[i]} + {1'b0, inflight_q[i]}) < (CW+1)'(RESP_DEPTH));
    end
  end

  // Round-robin pick: lowest eligible at/after ptr, else lowest eligible overall.
  always_comb begin
    lo_found_s = 1'b0;
    hi_found_s = 1'b0;
    lo_idx_s   = '0;
    hi_idx_s   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      lo_found_s = eligible_s[i] ? 1'b1 : lo_found_s;
      lo_idx_s   = eligible_s[i] ? IDW'(i) : lo_idx_s;
      hi_found_s = (eligible_s[i] && (IDW'(i) >= ptr_q)) ? 1'b1 : hi_found_s;
      hi_idx_s   = (eligible_s[i] && (IDW'(i) >= ptr_q)) ? IDW'(i) : hi_idx_s;
    end
    gnt_vld_s = lo_found_s && rst_n;
    gnt_idx_s = hi_found_s ? hi_idx_s : lo_idx_s;
    grant_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_s[i] = gnt_vld_s && (gnt_idx_s == IDW'(i));
    ptr_d = ptr_q;
    if (gnt_vld_s) begin
      ptr_d = (gnt_idx_s == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx_s + IDW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  assign req_ready = grant_s;

  // One-hot operand mux; all zero when nothing is granted.
  always_comb begin
    op1_s      = '0;
    op2_s      = '0;
    op1_sign_s = 1'b0;
    op2_sign_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op1_s      = op1_s | (req_op1[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
      op2_s      = op2_s | (req_op2[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
      op1_sign_s = op1_sign_s | (req_op1_sign[i] & grant_s[i]);
      op2_sign_s = op2_sign_s | (req_op2_sign[i] & grant_s[i]);
    end
  end

  assign tag_in_s.valid = gnt_vld_s;
  assign tag_in_s.id    = TAG_ID_W'(gnt_idx_s);
  assign tail_s         = tag_q[MUL_LATENCY-1];

  // Return routing and outstanding-op bookkeeping.
  always_comb begin
    push_s = '0;
    busy_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      push_s[i] = tail_s.valid && (tail_s.id == TAG_ID_W'(i));
      case ({grant_s[i], push_s[i]})
        2'b10:   inflight_d[i] = inflight_q[i] + CW'(1);
        2'b01:   inflight_d[i] = inflight_q[i] - CW'(1);
        default: inflight_d[i] = inflight_q[i];
      endcase
      busy_s = busy_s || (inflight_q[i] != '0) || (fifo_cnt_s[i] != '0);
    end
  end

  assign busy = busy_s;

  // Pointer, tag pipe and in-flight counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int k = 0; k < MUL_LATENCY; k++) tag_q[k] <= '0;
      for (int i = 0; i < NUM_REQ; i++) inflight_q[i] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      tag_q[0] <= tag_in_s;
      for (int k = 1; k < MUL_LATENCY; k++) tag_q[k] <= tag_q[k-1];
      for (int i = 0; i < NUM_REQ; i++) inflight_q[i] <= inflight_d[i];
    end
  end

  Multiplier #(.WIDTH(WIDTH), .LATENCY(MUL_LATENCY)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .op1      (op1_s),
    .op1_sign (op1_sign_s),
    .op2      (op2_s),
    .op2_sign (op2_sign_s),
    .result   (mul_result_s)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
    mul_arb_resp_fifo #(.DATA_W(DW), .DEPTH(RESP_DEPTH)) u_fifo (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .push_i  (push_s[g]),
      .data_i  (mul_result_s),
      .pop_i   (rsp_ready[g]),
      .valid_o (rsp_valid[g]),
      .data_o  (rsp_result[g*DW +: DW]),
      .cnt_o   (fifo_cnt_s[g])
    );
  end

`ifdef MUL_ARBITER_STATS_EN
  logic [31:0] issue_q [NUM_REQ];
  logic [31:0] stall_q [NUM_REQ];

  // Free-running, wrapping per-requester counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        issue_q[i] <= 32'd0;
        stall_q[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_s[i]) issue_q[i] <= issue_q[i] + 32'd1;
        if (req_valid[i] && !grant_s[i]) stall_q[i] <= stall_q[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_issue_cnt[g*32 +: 32] = issue_q[g];
    assign stat_stall_cnt[g*32 +: 32] = stall_q[g];
  end
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: per-requester scoreboard plus scenario tasks.
module tb_mul_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int L  = 3;
  localparam int D  = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR-1:0]  req_valid, req_ready, req_op1_sign, req_op2_sign;
  logic [NR-1:0]  rsp_valid, rsp_ready;
  logic [NR*W-1:0]   req_op1, req_op2;
  logic [NR*2*W-1:0] rsp_result;
  logic           busy;
`ifdef MUL_ARBITER_STATS_EN
  logic [NR*32-1:0] stat_issue_cnt, stat_stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q [NR][$];

  always #5 clk = ~clk;

  mul_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MUL_LATENCY(L), .RESP_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op1_sign(req_op1_sign),
    .req_op2(req_op2), .req_op2_sign(req_op2_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .busy(busy)
`ifdef MUL_ARBITER_STATS_EN
    , .stat_issue_cnt(stat_issue_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  function automatic logic [63:0] model(input logic [31:0] a, input logic sa,
                                        input logic [31:0] b, input logic sb);
    logic [63:0] ea, eb;
    ea = sa ? {{32{a[31]}}, a} : {32'h0, a};
    eb = sb ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  // Scoreboard: push on grant, pop and compare on response handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) exp_q[i].delete();
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          n_cmp++;
          if (exp_q[i].size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected[%0d]: got %h, required no response", i, rsp_result[i*64 +: 64]);
          end else if (rsp_result[i*64 +: 64] !== exp_q[i][0]) begin
            n_bad++;
            $display("FAIL sb_result[%0d]: got %h, required %h", i, rsp_result[i*64 +: 64], exp_q[i][0]);
            void'(exp_q[i].pop_front());
          end else begin
            void'(exp_q[i].pop_front());
          end
        end
        if (req_ready[i])
          exp_q[i].push_back(model(req_op1[i*32 +: 32], req_op1_sign[i], req_op2[i*32 +: 32], req_op2_sign[i]));
      end
    end
  end

  task automatic randomize_ops();
    for (int i = 0; i < NR; i++) begin
      req_op1[i*32 +: 32] = $urandom;
      req_op2[i*32 +: 32] = $urandom;
    end
    req_op1_sign = NR'($urandom);
    req_op2_sign = NR'($urandom);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_state: rsp_valid=%b busy=%b req_ready=%b, required 0/0/0", rsp_valid, busy, req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: rsp_valid=%b busy=%b, required 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    rsp_ready = '0; req_valid = 4'b0001;
    req_op1[31:0] = 32'd7; req_op2[31:0] = 32'd6; req_op1_sign = '0; req_op2_sign = '0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL single_grant: req_ready=%b, required 0001", req_ready);
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (L - 1) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (rsp_valid[0] !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL single_push_cycle: rsp_valid0=%b busy=%b, required 0/1", rsp_valid[0], busy);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid[0] !== 1'b1 || rsp_result[63:0] !== 64'd42) begin
      n_bad++; $display("FAIL single_result: valid=%b result=%h, required 1/42", rsp_valid[0], rsp_result[63:0]);
    end
    @(posedge clk); #1 rsp_ready = 4'b0001;
    @(posedge clk); #1 rsp_ready = '0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid[0] !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL single_drain: rsp_valid0=%b busy=%b, required 0/0", rsp_valid[0], busy);
    end
  endtask

  task automatic test_signed();
    logic [63:0] exp_c;
    for (int v = 0; v < 2; v++) begin
      exp_c = (v == 0) ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0004_FFFF_FFF1;
      @(posedge clk); #1;
      req_valid = 4'b0010; req_op1[63:32] = 32'hFFFF_FFFD; req_op2[63:32] = 32'd5;
      req_op1_sign = (v == 0) ? 4'b0010 : 4'b0000;
      req_op2_sign = (v == 0) ? 4'b0010 : 4'b0000;
      @(posedge clk); #1 req_valid = '0;
      for (int c = 0; c < 10 && !rsp_valid[1]; c++) @(negedge clk);
      n_cmp++;
      if (rsp_valid[1] !== 1'b1 || rsp_result[127:64] !== exp_c) begin
        n_bad++; $display("FAIL signed_v%0d: valid=%b result=%h, required 1/%h", v, rsp_valid[1], rsp_result[127:64], exp_c);
      end
      @(posedge clk); #1 rsp_ready = 4'b0010;
      @(posedge clk); #1 rsp_ready = '0;
    end
  endtask

  task automatic test_fairness();
    logic [3:0] one, exp_g;
    one = 4'b0001;
    pulse_reset();
    rsp_ready = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      req_valid = 4'b1111; randomize_ops();
      @(negedge clk);
      exp_g = one << (k % 4);
      n_cmp++;
      if (req_ready !== exp_g) begin
        n_bad++; $display("FAIL fair_grant_%0d: req_ready=%b, required %b", k, req_ready, exp_g);
      end
    end
    @(posedge clk); #1 req_valid = '0;
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL fair_drain: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_credit();
    int g0, g2, stall;
    g0 = 0; g2 = 0; stall = 0;
    pulse_reset();
    rsp_ready = 4'b1011;
    for (int k = 0; k < 13; k++) begin
      @(posedge clk); #1;
      req_valid = (k < 10) ? 4'b0101 : 4'b0100; randomize_ops();
      @(negedge clk);
      if (k >= 4) begin
        n_cmp++;
        if (req_ready[2] !== 1'b0) begin
          n_bad++; $display("FAIL credit_block_%0d: req_ready2=%b, required 0", k, req_ready[2]);
        end
      end
      g0 += int'(req_ready[0]); g2 += int'(req_ready[2]);
      stall += int'(req_valid[2] && !req_ready[2]);
    end
    n_cmp++;
    if (g2 != 2 || g0 == 0) begin
      n_bad++; $display("FAIL credit_grants: req2 grants=%0d req0 grants=%0d, required 2 and >0", g2, g0);
    end
    @(posedge clk); #1 rsp_ready = 4'b1111;
    @(negedge clk);
`ifdef MUL_ARBITER_STATS_EN
    n_cmp++;
    if (stat_issue_cnt[95:64] !== 32'(g2) || stat_stall_cnt[95:64] !== 32'(stall)) begin
      n_bad++; $display("FAIL stats: issue=%0d stall=%0d, required %0d/%0d", stat_issue_cnt[95:64], stat_stall_cnt[95:64], g2, stall);
    end
`endif
    n_cmp++;
    if (req_ready[2] !== 1'b0) begin
      n_bad++; $display("FAIL credit_pop_cycle: req_ready2=%b, required 0", req_ready[2]);
    end
    @(posedge clk); #1 rsp_ready = 4'b1011;
    @(negedge clk);
    n_cmp++;
    if (req_ready[2] !== 1'b1) begin
      n_bad++; $display("FAIL credit_reenable: req_ready2=%b, required 1", req_ready[2]);
    end
    @(negedge clk);
    n_cmp++;
    if (req_ready[2] !== 1'b0) begin
      n_bad++; $display("FAIL credit_single_extra: req_ready2=%b, required 0", req_ready[2]);
    end
    @(posedge clk); #1 req_valid = '0; rsp_ready = 4'b1111;
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL credit_drain: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      req_valid = 4'b1011; randomize_ops();
      @(negedge clk);
      n_cmp++;
      if ($countones(req_ready) != 1) begin
        n_bad++; $display("FAIL midflight_issue_%0d: req_ready=%b, required one-hot", k, req_ready);
      end
    end
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      n_bad++; $display("FAIL midflight_clear: rsp_valid=%b busy=%b req_ready=%b, required 0/0/0", rsp_valid, busy, req_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
        n_bad++; $display("FAIL midflight_ghost_%0d: rsp_valid=%b busy=%b, required 0/0", c, rsp_valid, busy);
      end
    end
    @(posedge clk); #1;
    req_valid = 4'b1000; req_op1[127:96] = 32'd1234; req_op2[127:96] = 32'hFFFF_FFFF;
    req_op1_sign = 4'b0000; req_op2_sign = 4'b1000;
    @(posedge clk); #1 req_valid = '0;
    for (int c = 0; c < 10 && !rsp_valid[3]; c++) @(negedge clk);
    n_cmp++;
    if (rsp_valid[3] !== 1'b1 || rsp_result[255:192] !== 64'hFFFF_FFFF_FFFF_FB2E) begin
      n_bad++; $display("FAIL midflight_next_op: valid=%b result=%h, required 1/FFFFFFFFFFFFFB2E", rsp_valid[3], rsp_result[255:192]);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_drain();
    int left;
    left = 0;
    for (int i = 0; i < NR; i++) left += exp_q[i].size();
    n_cmp++;
    if (left != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL drain_final: pending=%0d busy=%b, required 0/0", left, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    req_op1 = '0; req_op2 = '0; req_op1_sign = '0; req_op2_sign = '0;
    req_valid = 4'b1111;
    repeat (3) @(posedge clk);
    test_reset();
    test_single();
    test_signed();
    test_fairness();
    test_credit();
    test_reset_midflight();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
